// File: rtl/nf_reg_scan_arb.sv
// Three-source round-robin arbiter (req0, req1, auto-scan) sharing one scan port
// into the CPU register file; each read takes IDLE -> SAMPLE -> DONE.
module nf_reg_scan_arb #(
  parameter int unsigned DWELL_W = 24
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               req0,
  input  logic               req1,
  input  logic [4:0]         addr0,
  input  logic [4:0]         addr1,
  output logic               gnt0,
  output logic               gnt1,
  output logic [31:0]        data0,
  output logic [31:0]        data1,
  input  logic               auto_en,
  input  logic [DWELL_W-1:0] dwell,
  output logic [4:0]         auto_addr,
  output logic [31:0]        auto_data,
  output logic               auto_upd,
  output logic [4:0]         reg_addr,
  input  logic [31:0]        reg_data
);

  localparam int unsigned AW = 5;
  localparam int unsigned SW = 2;

  typedef enum logic [1:0] {IDLE, SAMPLE, DONE} state_t;

  state_t             state_q, state_d;
  logic [SW-1:0]      src_q;
  logic [SW-1:0]      prio_q;
  logic [SW-1:0]      win_src;
  logic               win_vld;
  logic [AW-1:0]      win_addr;
  logic [2:0]         pend_vec;
  logic [2:0]         idx;
  logic [2:0]         gnt_d;
  logic               auto_pend;
  logic [DWELL_W-1:0] cnt_q;
  logic [DWELL_W-1:0] dwell_eff;

  assign pend_vec  = {auto_pend, req1, req0};
  assign dwell_eff = (dwell == '0) ? DWELL_W'(1) : dwell;

  // Round-robin pick: prio_q is the highest-priority source this round.
  always_comb begin
    win_vld  = 1'b0;
    win_src  = 2'd0;
    idx      = 3'd0;
    win_addr = '0;
    for (int i = 2; i >= 0; i--) begin
      idx = 3'(prio_q) + 3'(i);
      if (idx >= 3'd3) idx = idx - 3'd3;
      if (pend_vec[idx[1:0]]) begin
        win_vld = 1'b1;
        win_src = idx[1:0];
      end
    end
    unique case (win_src)
      2'd0:    win_addr = addr0;
      2'd1:    win_addr = addr1;
      default: win_addr = auto_addr;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = 3'b000;
    unique case (state_q)
      IDLE:   if (win_vld) state_d = SAMPLE;
      SAMPLE: begin
        state_d = DONE;
        unique case (src_q)
          2'd0:    gnt_d[0] = 1'b1;
          2'd1:    gnt_d[1] = 1'b1;
          default: gnt_d[2] = 1'b1;
        endcase
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Transaction datapath: latch winner in IDLE, capture data at end of SAMPLE.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      src_q     <= '0;
      prio_q    <= '0;
      reg_addr  <= '0;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      auto_upd  <= 1'b0;
      data0     <= '0;
      data1     <= '0;
      auto_data <= '0;
    end else begin
      gnt0     <= gnt_d[0];
      gnt1     <= gnt_d[1];
      auto_upd <= gnt_d[2];
      if (state_q == IDLE && win_vld) begin
        src_q    <= win_src;
        prio_q   <= (win_src == 2'd2) ? 2'd0 : win_src + 2'd1;
        reg_addr <= win_addr;
      end
      if (state_q == SAMPLE) begin
        unique case (src_q)
          2'd0:    data0     <= reg_data;
          2'd1:    data1     <= reg_data;
          default: auto_data <= reg_data;
        endcase
      end
    end
  end

  // Auto-scan dwell timer; a finishing auto read advances the index even if auto_en dropped.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      auto_pend <= 1'b0;
      cnt_q     <= '0;
      auto_addr <= '0;
    end else if (state_q == DONE && src_q == 2'd2) begin
      auto_pend <= 1'b0;
      cnt_q     <= dwell_eff;
      auto_addr <= auto_addr + AW'(1);
    end else if (!auto_en) begin
      auto_pend <= 1'b0;
      cnt_q     <= dwell_eff;
    end else if (!auto_pend) begin
      if (cnt_q <= DWELL_W'(1)) begin
        auto_pend <= 1'b1;
        cnt_q     <= '0;
      end else begin
        cnt_q <= cnt_q - DWELL_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_nf_reg_scan_arb.sv
// Bench for nf_reg_scan_arb: directed scenarios plus random traffic, all checked
// cycle by cycle against a transaction-level reference model.
module tb_nf_reg_scan_arb;

  logic        clk;
  logic        resetn;
  logic        req0, req1;
  logic [4:0]  addr0, addr1;
  logic        gnt0, gnt1;
  logic [31:0] data0, data1;
  logic        auto_en;
  logic [23:0] dwell;
  logic [4:0]  auto_addr;
  logic [31:0] auto_data;
  logic        auto_upd;
  logic [4:0]  reg_addr;
  logic [31:0] reg_data;

  logic [31:0] regs [32];

  int n_total = 0;
  int n_bad   = 0;

  // reference model state
  int          m_busy;
  int          m_src;
  int          m_addr;
  int          m_prio;
  int          m_cnt;
  int          m_aaddr;
  int          m_regaddr;
  bit          m_pend;
  bit [2:0]    m_gnt;
  logic [31:0] m_data [3];
  bit [2:0]    prev_g;

  nf_reg_scan_arb #(.DWELL_W(24)) dut (
    .clk(clk), .resetn(resetn),
    .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
    .gnt0(gnt0), .gnt1(gnt1), .data0(data0), .data1(data1),
    .auto_en(auto_en), .dwell(dwell),
    .auto_addr(auto_addr), .auto_data(auto_data), .auto_upd(auto_upd),
    .reg_addr(reg_addr), .reg_data(reg_data)
  );

  assign reg_data = regs[reg_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_src = 0; m_addr = 0; m_prio = 0; m_cnt = 0;
    m_aaddr = 0; m_regaddr = 0; m_pend = 1'b0; m_gnt = 3'b000;
    for (int i = 0; i < 3; i++) m_data[i] = 32'h0;
    prev_g = 3'b000;
  endtask

  // One clock of the reference behaviour, from the inputs seen at the edge.
  task automatic model_step();
    int old_busy, old_src, deff, s;
    bit old_pend, found;
    bit [2:0] p;
    old_busy = m_busy;
    old_src  = m_src;
    old_pend = m_pend;
    deff     = (dwell == 24'd0) ? 1 : int'(dwell);
    m_gnt    = 3'b000;
    if (old_busy == 0) begin
      p = {old_pend, req1, req0};
      found = 1'b0;
      for (int k = 0; k < 3; k++) begin
        s = (m_prio + k) % 3;
        if (!found && p[s]) begin
          found     = 1'b1;
          m_src     = s;
          m_addr    = (s == 0) ? int'(addr0) : (s == 1) ? int'(addr1) : m_aaddr;
          m_regaddr = m_addr;
          m_prio    = (s + 1) % 3;
          m_busy    = 1;
        end
      end
    end else if (old_busy == 1) begin
      m_data[old_src] = regs[m_addr];
      m_gnt[old_src]  = 1'b1;
      m_busy = 2;
    end else begin
      m_busy = 0;
    end
    if (old_busy == 2 && old_src == 2) begin
      m_pend = 1'b0; m_cnt = deff; m_aaddr = (m_aaddr + 1) % 32;
    end else if (!auto_en) begin
      m_pend = 1'b0; m_cnt = deff;
    end else if (!old_pend) begin
      if (m_cnt <= 1) begin m_pend = 1'b1; m_cnt = 0; end
      else m_cnt = m_cnt - 1;
    end
  endtask

  // Advance one cycle and compare every output on the falling edge.
  task automatic tick();
    bit [2:0] g;
    @(posedge clk);
    if (resetn) model_step();
    @(negedge clk);
    g = {auto_upd, gnt1, gnt0};
    check_eq("gnt0",      32'(gnt0),      32'(m_gnt[0]));
    check_eq("gnt1",      32'(gnt1),      32'(m_gnt[1]));
    check_eq("auto_upd",  32'(auto_upd),  32'(m_gnt[2]));
    check_eq("data0",     data0,          m_data[0]);
    check_eq("data1",     data1,          m_data[1]);
    check_eq("auto_data", auto_data,      m_data[2]);
    check_eq("auto_addr", 32'(auto_addr), 32'(m_aaddr));
    check_eq("reg_addr",  32'(reg_addr),  32'(m_regaddr));
    check_eq("gnt_onehot", 32'($countones(g) <= 1), 32'd1);
    check_eq("gnt_width", 32'(g & prev_g), 32'd0);
    prev_g = g;
  endtask

  task automatic do_reset(input int cycles);
    resetn = 1'b0;
    model_reset();
    repeat (cycles) tick();
    resetn = 1'b1;
  endtask

  initial begin
    int n;
    resetn = 1'b0; req0 = 1'b0; req1 = 1'b0; addr0 = '0; addr1 = '0;
    auto_en = 1'b0; dwell = 24'd4;
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    regs[7] = 32'hDEADBEEF;
    model_reset();
    @(negedge clk);
    do_reset(3);

    // single read of x7, request accepted at the first edge after reset release
    req0 = 1'b1; addr0 = 5'd7;
    tick();
    req0 = 1'b0;
    check_eq("single_addr", 32'(reg_addr), 32'd7);
    check_eq("single_early", 32'(gnt0), 32'd0);
    tick();
    check_eq("single_gnt", 32'(gnt0), 32'd1);
    check_eq("single_data", data0, 32'hDEADBEEF);
    tick();
    check_eq("single_end", 32'(gnt0), 32'd0);
    repeat (3) tick();

    // contention from reset release, both held: S0, S1, S0
    resetn = 1'b0; model_reset();
    req0 = 1'b1; req1 = 1'b1; addr0 = 5'd3; addr1 = 5'd4;
    tick();
    resetn = 1'b1;
    tick(); tick();
    check_eq("cont_gnt0", 32'(gnt0), 32'd1);
    check_eq("cont_data0", data0, regs[3]);
    tick(); tick(); tick();
    check_eq("cont_gnt1", 32'(gnt1), 32'd1);
    check_eq("cont_data1", data1, regs[4]);
    tick(); tick(); tick();
    check_eq("cont_gnt0b", 32'(gnt0), 32'd1);
    req0 = 1'b0; req1 = 1'b0;
    repeat (4) tick();

    // request dropped after one cycle still completes, no repeat grant
    req1 = 1'b1; addr1 = 5'd9;
    tick();
    req1 = 1'b0; addr1 = 5'($urandom_range(0, 31));
    tick();
    check_eq("drop_gnt", 32'(gnt1), 32'd1);
    check_eq("drop_data", data1, regs[9]);
    for (int i = 0; i < 6; i++) begin
      tick();
      check_eq("drop_nogrant", 32'(gnt1), 32'd0);
    end

    // auto-scan sweep through all 32 registers and the wrap back to 0
    do_reset(2);
    auto_en = 1'b1; dwell = 24'd4;
    n = 0;
    for (int c = 0; c < 600 && n < 33; c++) begin
      tick();
      if (auto_upd) begin
        check_eq("auto_seq_addr", 32'(auto_addr), 32'(n % 32));
        check_eq("auto_seq_data", auto_data, regs[n % 32]);
        n++;
      end
    end
    check_eq("auto_pulses", 32'(n), 32'd33);
    auto_en = 1'b0;
    repeat (4) tick();

    // reset asserted during SAMPLE aborts the read
    req0 = 1'b1; addr0 = 5'd5;
    tick();
    req0 = 1'b0;
    resetn = 1'b0; model_reset();
    #1;
    check_eq("rst_gnt0", 32'(gnt0), 32'd0);
    check_eq("rst_data0", data0, 32'd0);
    check_eq("rst_regaddr", 32'(reg_addr), 32'd0);
    check_eq("rst_autoaddr", 32'(auto_addr), 32'd0);
    check_eq("rst_autodata", auto_data, 32'd0);
    tick(); tick();
    resetn = 1'b1;
    req0 = 1'b1; addr0 = 5'd5;
    tick();
    req0 = 1'b0;
    tick();
    check_eq("post_rst_gnt", 32'(gnt0), 32'd1);
    check_eq("post_rst_data", data0, regs[5]);
    tick();

    // random traffic with occasional resets
    for (int c = 0; c < 2500; c++) begin
      req0    = ($urandom_range(0, 2) != 0);
      req1    = ($urandom_range(0, 2) != 0);
      addr0   = 5'($urandom_range(0, 31));
      addr1   = 5'($urandom_range(0, 31));
      auto_en = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 15) == 0) dwell = 24'($urandom_range(0, 6));
      if ($urandom_range(0, 499) == 0) begin
        do_reset(1);
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/nf_reg_scan_arb.md
NF_REG_SCAN_ARB -- requirements
Module: nf_reg_scan_arb

Interface
REQ-001 SHALL have parameter DWELL_W, default 24, width of the auto-scan dwell counter.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port resetn  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports req0/req1  input  1  read request from requester 0/1 (held until grant).
REQ-005 SHALL have ports addr0/addr1  input  5  register index requested by requester 0/1.
REQ-006 SHALL have ports gnt0/gnt1  output  1  one-cycle pulse; the matching data0/data1 is valid in the same cycle.
REQ-007 SHALL have ports data0/data1  output  32  captured register value per requester, held until that requester's next grant.
REQ-008 SHALL have port auto_en  input  1  enables the auto-scan requester.
REQ-009 SHALL have port dwell  input  DWELL_W  cycles between auto-scan reads.
REQ-010 SHALL have ports auto_addr  output  5, auto_data  output  32, auto_upd  output  1  current auto index, its last value, and a one-cycle update pulse.
REQ-011 SHALL have port reg_addr  output  5  registered scan address to the CPU register file.
REQ-012 SHALL have port reg_data  input  32  combinational scan data returned for reg_addr.

Function
REQ-013 SHALL implement FSM IDLE -> SAMPLE -> DONE -> IDLE; IDLE stays IDLE while no source is pending.
REQ-014 SHALL treat three sources: S0=req0, S1=req1, S2=auto_pend, arbitrated round-robin; the last-granted source gets lowest priority; after reset the priority order is S0>S1>S2.
REQ-015 SHALL, at the IDLE edge where a winner exists, latch the winner ID and load reg_addr with its address (addr0, addr1 or auto_addr).
REQ-016 SHALL, at the end of SAMPLE, capture reg_data into the winner's data register.
REQ-017 SHALL assert the winner's grant (gnt0, gnt1 or auto_upd) for exactly the DONE cycle; request seen at edge k gives grant high in cycle k+2.
REQ-018 SHALL complete and grant a transaction whose req drops after being latched; the address is not re-sampled.
REQ-019 SHALL treat req still high in IDLE after DONE as a new request, so a held req yields one read every 3 cycles when uncontested.
REQ-020 SHALL hold reg_addr at its last value in IDLE and DONE.
REQ-021 SHALL, while auto_en=1 and auto_pend=0, decrement the dwell counter each cycle and set auto_pend when it reaches 0; dwell=0 is treated as 1.
REQ-022 SHALL, on auto grant, clear auto_pend, increment auto_addr modulo 32 (31 wraps to 0), and reload the counter from dwell.
REQ-023 SHALL, when auto_en=0, clear auto_pend and load the counter from dwell; auto_addr and auto_data hold; an auto transaction already latched completes normally.
REQ-024 SHALL never assert more than one of gnt0, gnt1, auto_upd in any cycle.

Reset
REQ-025 SHALL, on resetn=0, immediately set FSM=IDLE, reg_addr=0, gnt0=gnt1=auto_upd=0, data0=data1=auto_data=0, auto_addr=0, auto_pend=0, counter=0, and priority pointer to S0.
REQ-026 SHALL abort any in-flight transaction on reset with no grant, and SHALL accept the first request at the first clock edge after resetn rises.

Verification
REQ-027 SHALL verify a single read: reg x7=0xDEADBEEF, req0=1, addr0=7 at edge k -> reg_addr=7 from k+1, gnt0 high in cycle k+2, data0=0xDEADBEEF.
REQ-028 SHALL verify contention: req0 and req1 both rise at reset release with addr0=3, addr1=4 -> gnt0 first (data0=x3), then gnt1 3 cycles later (data1=x4); both held high alternate S0,S1,S0.
REQ-029 SHALL verify auto-scan: auto_en=1, dwell=4, no other requests -> auto_upd pulses periodically with auto_addr 0,1,2,..., 31 then 0; auto_data matches each register.
REQ-030 SHALL verify a dropped request: req1 high for 1 cycle with addr1=9 -> gnt1 still pulses 2 cycles later with data1=x9, and no second grant follows.
REQ-031 SHALL verify reset mid-transaction: resetn low during SAMPLE -> no grant, all outputs zero, next req0 served normally.
REQ-032 SHALL verify with a checker that at most one grant is high per cycle and that each grant is exactly one cycle wide across random req/auto_en/dwell stimulus.
